// File: rtl/bus_dma_copy.sv
// rtl/bus_dma_copy.sv - chunked block copy engine over the single-port memory bus
module bus_dma_copy #(
   parameter int BURST     = 4,
   parameter int LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [31:0]          src_addr,
   input  logic [31:0]          dst_addr,
   input  logic [LEN_WIDTH-1:0] len,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [31:0]          err_addr,
   output logic                 m_enable,
   output logic                 m_wr_en,
   output logic [31:0]          m_addr,
   output logic [31:0]          m_wdata,
   output logic [3:0]           m_be,
   input  logic [31:0]          m_rdata,
   input  logic                 m_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_RD    = 3'd2;
   localparam logic [2:0] S_RGAP  = 3'd3;
   localparam logic [2:0] S_WR    = 3'd4;
   localparam logic [2:0] S_WGAP  = 3'd5;
   localparam logic [2:0] S_FIN   = 3'd6;

   // Beat counter must reach BURST+2 (read latency tail); chunk size reaches BURST.
   localparam int CW = 6;
   localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;

   logic [2:0]           state_q;
   logic [31:0]          src_q;
   logic [31:0]          dst_q;
   logic [LEN_WIDTH-1:0] rem_q;
   logic [CW-1:0]        chunk_q;
   logic [CW-1:0]        cnt_q;
   logic [31:0]          data_buf [BURST];

   logic [31:0]          src_nxt;
   logic [31:0]          dst_nxt;
   logic [LEN_WIDTH-1:0] rem_nxt;
   logic                 cap_en;
   logic [IW-1:0]        cap_idx;

   // Words in the next chunk: the full buffer, or whatever is left.
   function automatic logic [CW-1:0] chunk_of(input logic [LEN_WIDTH-1:0] r);
      if (r >= LEN_WIDTH'(BURST)) begin
         return CW'(BURST);
      end
      return CW'(r);
   endfunction

   // Byte enables never vary: every beat moves a full word.
   assign m_be = 4'b1111;

   // Addresses and count after the current chunk retires; addition wraps mod 2^32.
   always_comb begin
      src_nxt = src_q + {{(32-CW-2){1'b0}}, chunk_q, 2'b00};
      dst_nxt = dst_q + {{(32-CW-2){1'b0}}, chunk_q, 2'b00};
      rem_nxt = rem_q - LEN_WIDTH'(chunk_q);
   end

   // Read beats land from the third cycle of the read burst onward.
   always_comb begin
      cap_en  = (state_q == S_RD) && (cnt_q >= CW'(3));
      cap_idx = IW'(cnt_q - CW'(3));
   end

   // Chunk buffer: plain storage, no reset needed.
   always_ff @(posedge clk) begin
      if (cap_en) begin
         data_buf[cap_idx] <= m_rdata;
      end
   end

   // Control FSM and registered bus outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         rem_q    <= '0;
         chunk_q  <= '0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_addr <= '0;
         m_enable <= 1'b0;
         m_wr_en  <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
      end else begin
         done <= 1'b0;
         if (m_enable && m_err) begin
            // Abort the burst at once and report its base address.
            m_enable <= 1'b0;
            m_wr_en  <= 1'b0;
            err      <= 1'b1;
            err_addr <= m_wr_en ? dst_q : src_q;
            state_q  <= S_FIN;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     src_q   <= src_addr;
                     dst_q   <= dst_addr;
                     rem_q   <= len;
                     err     <= 1'b0;
                     busy    <= 1'b1;
                     state_q <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (src_q[1:0] != 2'b00) begin
                     err_addr <= src_q;
                     err      <= 1'b1;
                     state_q  <= S_FIN;
                  end else if (dst_q[1:0] != 2'b00) begin
                     err_addr <= dst_q;
                     err      <= 1'b1;
                     state_q  <= S_FIN;
                  end else if (rem_q == '0) begin
                     state_q  <= S_FIN;
                  end else begin
                     chunk_q  <= chunk_of(rem_q);
                     cnt_q    <= '0;
                     state_q  <= S_RD;
                  end
               end
               S_RD: begin
                  // cnt_q counts edges since enable rose; the address stays put
                  // because the responder advances its own offset.
                  if (cnt_q == '0) begin
                     m_enable <= 1'b1;
                     m_wr_en  <= 1'b0;
                     m_addr   <= src_q;
                     cnt_q    <= CW'(1);
                  end else if (cnt_q == chunk_q + CW'(2)) begin
                     m_enable <= 1'b0;
                     state_q  <= S_RGAP;
                  end else begin
                     cnt_q    <= cnt_q + CW'(1);
                  end
               end
               S_RGAP: begin
                  m_enable <= 1'b1;
                  m_wr_en  <= 1'b1;
                  m_addr   <= dst_q;
                  m_wdata  <= data_buf[0];
                  cnt_q    <= CW'(1);
                  state_q  <= S_WR;
               end
               S_WR: begin
                  if (cnt_q == chunk_q) begin
                     m_enable <= 1'b0;
                     m_wr_en  <= 1'b0;
                     state_q  <= S_WGAP;
                  end else begin
                     m_wdata  <= data_buf[IW'(cnt_q)];
                     cnt_q    <= cnt_q + CW'(1);
                  end
               end
               S_WGAP: begin
                  // Retire the chunk and either open the next read burst on
                  // this same edge or finish.
                  src_q <= src_nxt;
                  dst_q <= dst_nxt;
                  rem_q <= rem_nxt;
                  if (rem_nxt != '0) begin
                     chunk_q  <= chunk_of(rem_nxt);
                     m_enable <= 1'b1;
                     m_wr_en  <= 1'b0;
                     m_addr   <= src_nxt;
                     cnt_q    <= CW'(1);
                     state_q  <= S_RD;
                  end else begin
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     state_q  <= S_IDLE;
                  end
               end
               S_FIN: begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bus_dma_copy.sv
// tb/tb_bus_dma_copy.sv - directed vector bench for bus_dma_copy with a behavioural responder
module tb_bus_dma_copy;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] len;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] err_addr;
   logic        m_enable;
   logic        m_wr_en;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic [31:0] m_rdata = '0;
   logic        m_err = 1'b0;

   bus_dma_copy #(.BURST(4), .LEN_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
      .err_addr(err_addr), .m_enable(m_enable), .m_wr_en(m_wr_en),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_rdata(m_rdata),
      .m_err(m_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder memory and bus bookkeeping, all owned by the negedge process.
   logic [31:0] mem [256];
   logic        ld_en = 1'b0;
   logic [7:0]  ld_idx = '0;
   logic [31:0] ld_val = '0;
   int          inj_target = 0;
   logic        en_q = 1'b0;
   int          cyc = 0;
   int          rd_total = 0;
   int          wr_total = 0;
   int          gap_bad = 0;
   int          low_run = 0;
   logic        low_ok = 1'b0;

   int n_checks = 0;
   int n_err = 0;

   // Fixed-latency responder: read word k valid for the edge three cycles plus k
   // after enable rose; write word k taken from the cycle k after enable rose.
   always @(negedge clk) begin
      int i;
      int nrd;
      logic rise;
      rise = m_enable && !en_q;
      i = rise ? 0 : cyc;
      nrd = rd_total;
      if (ld_en) mem[ld_idx] <= ld_val;
      en_q <= m_enable;
      if (m_enable) begin
         cyc <= i + 1;
         if (rise) begin
            if (m_wr_en) wr_total <= wr_total + 1;
            else begin
               nrd = rd_total + 1;
               rd_total <= nrd;
            end
            if (low_ok && low_run != 1) gap_bad <= gap_bad + 1;
         end
         low_run <= 0;
         low_ok <= 1'b1;
         if (m_wr_en) mem[8'(m_addr[9:2] + 8'(i))] <= m_wdata;
         else if (i >= 2) m_rdata <= mem[8'(m_addr[9:2] + 8'(i - 2))];
         m_err <= !m_wr_en && inj_target != 0 && nrd == inj_target;
      end else begin
         cyc <= 0;
         low_run <= low_run + 1;
         if (!busy) low_ok <= 1'b0;
         m_err <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load(input logic [7:0] idx, input logic [31:0] val);
      ld_idx = idx;
      ld_val = val;
      ld_en = 1'b1;
      @(negedge clk);
      #1;
      ld_en = 1'b0;
   endtask

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] len;
      logic [31:0] seed;
      int          inj;
      logic        exp_err;
      logic [31:0] exp_eaddr;
      int          exp_done;
      int          exp_rd;
      int          exp_wr;
      int          copied;
   } vec_t;

   vec_t vecs [9];
   vec_t vrst;

   task automatic run_vec(input vec_t v, input bit poke);
      int rd0, wr0, g0, first_en, c, bad;
      logic got;
      logic [31:0] expw;
      for (int i = 0; i < int'(v.len); i++) load(8'(v.dst[9:2] + 8'(i)), 32'hDEAD0000 + i);
      for (int i = 0; i < int'(v.len); i++) load(8'(v.src[9:2] + 8'(i)), v.seed + i);
      rd0 = rd_total;
      wr0 = wr_total;
      g0 = gap_bad;
      inj_target = (v.inj != 0) ? rd0 + v.inj : 0;
      src_addr = v.src;
      dst_addr = v.dst;
      len = v.len;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      got = 1'b0;
      c = -1;
      first_en = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (k == 0) check("busy_after_start", {31'b0, busy}, 32'd1);
         if (m_enable && first_en < 0) first_en = k;
         if (done) begin
            got = 1'b1;
            c = k;
            break;
         end
         if (poke && k == 5) begin
            start = 1'b1;
            src_addr = 32'h13;
            len = 16'd1;
         end else start = 1'b0;
      end
      start = 1'b0;
      check("done_seen", {31'b0, got}, 32'd1);
      check("done_cycle", c, v.exp_done);
      check("err_flag", {31'b0, err}, {31'b0, v.exp_err});
      if (v.exp_err) check("err_addr", err_addr, v.exp_eaddr);
      @(negedge clk);
      check("done_busy_after", {30'b0, done, busy}, 32'd0);
      @(negedge clk);
      check("rd_bursts", rd_total - rd0, v.exp_rd);
      check("wr_bursts", wr_total - wr0, v.exp_wr);
      check("gap_len", gap_bad - g0, 32'd0);
      check("first_enable", first_en, (v.exp_rd > 0) ? 2 : -1);
      bad = 0;
      for (int i = 0; i < int'(v.len); i++) begin
         expw = (i < v.copied) ? v.seed + i : 32'hDEAD0000 + i;
         if (mem[8'(v.dst[9:2] + 8'(i))] !== expw) bad++;
      end
      check("dst_words_bad", bad, 32'd0);
      inj_target = 0;
   endtask

   initial begin
      logic seen;
      rst_n = 1'b0;
      start = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len = '0;
      repeat (2) @(negedge clk);
      check("rst_ctrl", {27'b0, busy, done, err, m_enable, m_wr_en}, 32'd0);
      check("rst_err_addr", err_addr, 32'd0);
      check("rst_m_addr", m_addr, 32'd0);
      check("rst_m_wdata", m_wdata, 32'd0);
      check("rst_m_be", {28'b0, m_be}, 32'hF);
      rst_n = 1'b1;
      @(negedge clk);

      //            src       dst       len    seed          inj err   eaddr     done rd wr copied
      vecs[0] = '{32'h10,  32'h40,  16'd1,  32'h11223344, 0, 1'b0, 32'h0,   8,  1, 1, 1};
      vecs[1] = '{32'h60,  32'h100, 16'd10, 32'h98765432, 0, 1'b0, 32'h0,   34, 3, 3, 10};
      vecs[2] = '{32'h12,  32'h40,  16'd4,  32'h01020304, 0, 1'b1, 32'h12,  2,  0, 0, 0};
      vecs[3] = '{32'h20,  32'h80,  16'd0,  32'h0,        0, 1'b0, 32'h0,   2,  0, 0, 0};
      vecs[4] = '{32'h200, 32'h300, 16'd8,  32'hC0DE0000, 2, 1'b1, 32'h210, 16, 2, 1, 4};
      vecs[5] = '{32'h20,  32'h41,  16'd2,  32'h55550000, 0, 1'b1, 32'h41,  2,  0, 0, 0};
      vecs[6] = '{32'h21,  32'h42,  16'd2,  32'h66660000, 0, 1'b1, 32'h21,  2,  0, 0, 0};
      vecs[7] = '{32'h80,  32'hC0,  16'd4,  32'h7A7A0000, 0, 1'b0, 32'h0,   14, 1, 1, 4};
      vecs[8] = '{32'h90,  32'hD0,  16'd5,  32'h3C3C0000, 0, 1'b0, 32'h0,   20, 2, 2, 5};

      for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

      // Reset in the middle of a write burst.
      src_addr = 32'h200;
      dst_addr = 32'h300;
      len = 16'd8;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (m_wr_en) begin
            seen = 1'b1;
            break;
         end
      end
      check("wr_burst_seen", {31'b0, seen}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl", {27'b0, busy, done, err, m_enable, m_wr_en}, 32'd0);
      check("midrst_m_addr", m_addr, 32'd0);
      check("midrst_m_wdata", m_wdata, 32'd0);
      check("midrst_err_addr", err_addr, 32'd0);
      check("midrst_m_be", {28'b0, m_be}, 32'hF);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fresh copy after reset, with a stray start pulse while busy.
      vrst = '{32'h40, 32'h140, 16'd6, 32'h0BADF00D, 0, 1'b0, 32'h0, 22, 2, 2, 6};
      run_vec(vrst, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
